dds_wave_gen: RTL and testbench
===============================

// Module: dds_wave_gen
// PURPOSE
//   Parametrised DDS waveform generator; successor to the fixed key-driven ROM player.
//   Phase accumulator drives a sine ROM (external, 1-cycle read) plus internally computed
//   square/sawtooth/triangle waves. Mode, frequency step and attenuation are cycled by
//   single-cycle pulses from upstream ax_debounce negedge outputs. Output feeds the DAC.
// PARAMETERS
//   DATA_W      8    output/ROM sample width
//   ADDR_W      8    sine ROM address width (top ADDR_W bits of phase); ADDR_W >= 2
//   PHASE_W     16   phase accumulator width; PHASE_W >= DATA_W+1 and >= ADDR_W
//   DIV         4    clocks per output sample (>= 2)
//   FWORD_BASE  256  phase increment at freq_sel=0
//   FREQ_LEVELS 4    number of freq_sel values; fword = FWORD_BASE << freq_sel
//   AMP_LEVELS  4    number of amp_sel values; output = wave >> amp_sel
// PORTS
//   clk         in   1                       system clock
//   rst_n       in   1                       async active-low reset
//   mode_step   in   1                       1-clk pulse: mode <= mode+1 (wraps 3->0)
//   freq_step   in   1                       1-clk pulse: freq_sel+1, wraps FREQ_LEVELS-1->0
//   amp_step    in   1                       1-clk pulse: amp_sel+1, wraps AMP_LEVELS-1->0
//   phase_clr   in   1                       1-clk pulse: clear phase accumulator
//   rom_addr    out  ADDR_W                  sine ROM address (registered)
//   rom_rden    out  1                       sine ROM read enable
//   rom_q       in   DATA_W                  ROM data; rom_q in cycle N = ROM[rom_addr in N-1]
//   dout        out  DATA_W                  waveform sample (registered)
//   dout_valid  out  1                       1-clk pulse when dout updates
//   mode        out  2                       0 sine, 1 square, 2 sawtooth, 3 triangle
//   freq_sel    out  $clog2(FREQ_LEVELS)     current frequency index
//   amp_sel     out  $clog2(AMP_LEVELS)      current attenuation shift
// BEHAVIOUR
//   Reset (async, rst_n=0): phase, prescaler, mode, freq_sel, amp_sel, rom_addr, dout = 0;
//     dout_valid=0, rom_rden=0; all pipeline regs 0. Release: rom_rden=1 from first clk edge.
//   Prescaler cnt 0..DIV-1; internal tick when cnt==DIV-1. First tick in cycle DIV-1 after release.
//   Step pulses update mode/freq_sel/amp_sel registers immediately (visible next cycle);
//     pipeline samples them only at tick -> settings change on sample boundary, no mid-sample mix.
//   Simultaneous step pulses: each applied independently same cycle.
//   Phase: at tick edge phase <= phase + (FWORD_BASE << freq_sel), mod 2^PHASE_W (silent wrap).
//     phase_clr: phase <= 0 at next edge, overrides tick add in same cycle; prescaler unaffected.
//   Pipeline (tick in cycle T):
//     end T:   phase updated; mode/amp_sel snapshot taken.
//     end T+1: rom_addr <= phase[PHASE_W-1 -: ADDR_W]; square/saw/tri computed from new phase.
//     end T+3: dout <= sel(mode_snap) >> amp_snap; dout_valid=1 during T+4 only.
//     First dout_valid after reset: cycle DIV+3. Steady state: one pulse every DIV clocks.
//   Waves (p = phase after update, m = p[PHASE_W-1]):
//     sine     = rom_q
//     square   = m ? 0 : {DATA_W{1'b1}}
//     sawtooth = p[PHASE_W-1 -: DATA_W]
//     triangle = m ? ~p[PHASE_W-2 -: DATA_W] : p[PHASE_W-2 -: DATA_W]
//     computed waves delayed to align with rom_q; shift right is logical, zero-fill.
//   dout holds between valid pulses. Reset mid-operation: all outputs to reset values at once.
// TESTING (defaults unless stated)
//   Reset release, mode=2 -> dout_valid first in cycle 7, dout=1,2,3,... each pulse, period 4 clk.
//   Sawtooth wrap: 256 samples -> dout 255 then 0; no glitch, valid spacing stays 4.
//   freq_step x1 mid-sample -> subsequent saw steps of 2; freq_step x4 total -> back to step 1.
//   mode=1, amp_step x2 -> dout alternates 63 / 0, 128 samples each half period.
//   mode=3 -> dout rises 0,2,4..254 then 255,253..1; phase_clr + tick same cycle -> next dout 0.
//   mode=0 with ROM model -> dout == ROM[k] for k-th sample; rst_n low mid-run -> dout=0, valid=0.

Source files
------------

// File: rtl/dds_wave_gen.sv
//==============================================================================
// dds_wave_gen : DDS generator producing sine (external ROM), square, saw and
//                triangle samples, one every DIV clocks, with step controls.
// Revision 1.0
//==============================================================================
`default_nettype none

module dds_wave_gen #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int PHASE_W     = 16,
    parameter int DIV         = 4,
    parameter int FWORD_BASE  = 256,
    parameter int FREQ_LEVELS = 4,
    parameter int AMP_LEVELS  = 4,
    localparam int FS_W       = (FREQ_LEVELS > 1) ? $clog2(FREQ_LEVELS) : 1,
    localparam int AS_W       = (AMP_LEVELS > 1) ? $clog2(AMP_LEVELS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_step,
    input  logic              freq_step,
    input  logic              amp_step,
    input  logic              phase_clr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rden,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [1:0]        mode,
    output logic [FS_W-1:0]   freq_sel,
    output logic [AS_W-1:0]   amp_sel
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [FS_W-1:0]    c_FREQ_MAX = FS_W'(FREQ_LEVELS - 1);
    localparam logic [AS_W-1:0]    c_AMP_MAX  = AS_W'(AMP_LEVELS - 1);
    localparam logic [PHASE_W-1:0] c_FWORD    = PHASE_W'(FWORD_BASE);

    logic [CNT_W-1:0]   r_cnt;
    logic [PHASE_W-1:0] r_phase;
    logic [1:0]         r_mode;
    logic [FS_W-1:0]    r_freq_sel;
    logic [AS_W-1:0]    r_amp_sel;
    logic               r_rden;
    logic [ADDR_W-1:0]  r_rom_addr;

    // Pipeline stages; each carries its own copy of the settings snapshot
    logic               r_v1, r_v2, r_v3, r_valid;
    logic [1:0]         r_mode1;
    logic [AS_W-1:0]    r_amp1, r_amp2, r_amp3;
    logic               r_sine2, r_sine3;
    logic [DATA_W-1:0]  r_wave2, r_wave3;
    logic [DATA_W-1:0]  r_dout;

    logic               w_tick;
    logic [PHASE_W-1:0] w_fword;
    logic [DATA_W-1:0]  w_tri_raw;
    logic [DATA_W-1:0]  w_wave_calc;
    logic [DATA_W-1:0]  w_wave_sel;

    assign w_tick    = (r_cnt == c_CNT_MAX);
    assign w_fword   = c_FWORD << r_freq_sel;
    assign w_tri_raw = r_phase[PHASE_W-2 -: DATA_W];

    always_comb begin
        w_wave_calc = '0;
        case (r_mode1)
            2'd1:    w_wave_calc = r_phase[PHASE_W-1] ? '0 : '1;
            2'd2:    w_wave_calc = r_phase[PHASE_W-1 -: DATA_W];
            2'd3:    w_wave_calc = r_phase[PHASE_W-1] ? ~w_tri_raw : w_tri_raw;
            default: w_wave_calc = '0;
        endcase
    end

    assign w_wave_sel = r_sine3 ? rom_q : r_wave3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_phase    <= '0;
            r_mode     <= '0;
            r_freq_sel <= '0;
            r_amp_sel  <= '0;
            r_rden     <= 1'b0;
        end else begin
            r_rden <= 1'b1;
            r_cnt  <= w_tick ? '0 : r_cnt + 1'b1;
            // A clear wins over the tick's increment in the same cycle
            if (phase_clr)
                r_phase <= '0;
            else if (w_tick)
                r_phase <= r_phase + w_fword;
            if (mode_step)
                r_mode <= r_mode + 2'd1;
            if (freq_step)
                r_freq_sel <= (r_freq_sel == c_FREQ_MAX) ? '0 : r_freq_sel + 1'b1;
            if (amp_step)
                r_amp_sel <= (r_amp_sel == c_AMP_MAX) ? '0 : r_amp_sel + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_valid    <= 1'b0;
            r_mode1    <= '0;
            r_amp1     <= '0;
            r_amp2     <= '0;
            r_amp3     <= '0;
            r_sine2    <= 1'b0;
            r_sine3    <= 1'b0;
            r_wave2    <= '0;
            r_wave3    <= '0;
            r_rom_addr <= '0;
            r_dout     <= '0;
        end else begin
            r_v1    <= w_tick;
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            r_valid <= r_v3;
            if (w_tick) begin
                r_mode1 <= r_mode;
                r_amp1  <= r_amp_sel;
            end
            if (r_v1) begin
                r_rom_addr <= r_phase[PHASE_W-1 -: ADDR_W];
                r_wave2    <= w_wave_calc;
                r_sine2    <= (r_mode1 == 2'd0);
                r_amp2     <= r_amp1;
            end
            // Extra stage lines computed waves up with the ROM read latency
            if (r_v2) begin
                r_wave3 <= r_wave2;
                r_sine3 <= r_sine2;
                r_amp3  <= r_amp2;
            end
            if (r_v3)
                r_dout <= w_wave_sel >> r_amp3;
        end
    end

    assign rom_addr   = r_rom_addr;
    assign rom_rden   = r_rden;
    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign mode       = r_mode;
    assign freq_sel   = r_freq_sel;
    assign amp_sel    = r_amp_sel;

endmodule

`default_nettype wire

// File: tb/tb_dds_wave_gen.sv
//==============================================================================
// tb_dds_wave_gen : directed bench with a reference model feeding an expected-
//                   sample queue that is drained on every dout_valid pulse.
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_dds_wave_gen;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_step = 1'b0, freq_step = 1'b0, amp_step = 1'b0, phase_clr = 1'b0;
    logic [7:0] rom_addr;
    logic       rom_rden;
    logic [7:0] rom_q = 8'd0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [1:0] mode;
    logic [1:0] freq_sel;
    logic [1:0] amp_sel;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rom [256];

    dds_wave_gen #(
        .DATA_W(8), .ADDR_W(8), .PHASE_W(16), .DIV(DIV),
        .FWORD_BASE(256), .FREQ_LEVELS(4), .AMP_LEVELS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mode_step(mode_step), .freq_step(freq_step),
        .amp_step(amp_step), .phase_clr(phase_clr),
        .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_q(rom_q),
        .dout(dout), .dout_valid(dout_valid),
        .mode(mode), .freq_sel(freq_sel), .amp_sel(amp_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rom_rden) rom_q <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: settings, phase and prescaler; pushes the expected
    // sample for every tick.
    logic [15:0] m_phase = '0;
    logic [1:0]  m_mode = '0, m_freq = '0, m_amp = '0;
    int          m_cnt = 0;
    int          cyc = 0;
    logic [7:0]  exp_q [$];

    function automatic logic [7:0] wave(input logic [15:0] p, input logic [1:0] md,
                                        input logic [1:0] am);
        logic [7:0] w;
        case (md)
            2'd0:    w = rom[p[15:8]];
            2'd1:    w = p[15] ? 8'd0 : 8'd255;
            2'd2:    w = p[15:8];
            default: w = p[15] ? ~p[14:7] : p[14:7];
        endcase
        return w >> am;
    endfunction

    initial begin
        logic [15:0] np;
        bit          tk;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = '0; m_mode = '0; m_freq = '0; m_amp = '0;
                m_cnt = 0; cyc = 0;
                exp_q.delete();
            end else begin
                cyc++;
                tk = (m_cnt == DIV - 1);
                np = phase_clr ? 16'd0 : (tk ? m_phase + (16'd256 << m_freq) : m_phase);
                if (tk) exp_q.push_back(wave(np, m_mode, m_amp));
                m_phase = np;
                m_cnt   = tk ? 0 : m_cnt + 1;
                if (mode_step) m_mode = m_mode + 2'd1;
                if (freq_step) m_freq = (m_freq == 2'd3) ? 2'd0 : m_freq + 2'd1;
                if (amp_step)  m_amp  = (m_amp == 2'd3) ? 2'd0 : m_amp + 2'd1;
            end
        end
    end

    // Monitor: scoreboard pop, valid timing and settings outputs on each pulse
    initial begin
        int         last_v;
        logic [7:0] e;
        last_v = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_v = 0;
            end else if (dout_valid) begin
                if (last_v == 0) check("first_valid_cycle", cyc, DIV + 3);
                else             check("valid_spacing", cyc - last_v, DIV);
                last_v = cyc;
                n_tests++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL sb_underflow: observed dout %0d expected no pulse", dout);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_dout", dout, e);
                end
                check("mode_out", mode, m_mode);
                check("freq_out", freq_sel, m_freq);
                check("amp_out", amp_sel, m_amp);
            end
        end
    end

    task automatic wait_valid(output logic [7:0] d);
        bit found = 0;
        d = '0;
        for (int i = 0; i < 4 * DIV + 8; i++) begin
            @(negedge clk);
            if (dout_valid) begin
                d = dout;
                found = 1;
                break;
            end
        end
        check("valid_timeout", found, 1);
    endtask

    task automatic skip_valid(input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) wait_valid(d);
    endtask

    task automatic pulse_mode();
        mode_step = 1'b1; @(negedge clk); mode_step = 1'b0;
    endtask
    task automatic pulse_freq();
        freq_step = 1'b1; @(negedge clk); freq_step = 1'b0;
    endtask
    task automatic pulse_amp();
        amp_step = 1'b1; @(negedge clk); amp_step = 1'b0;
    endtask

    initial begin
        logic [7:0] d, d1, prev;
        bit         seen;
        int         c_hi, c_lo, guard;

        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_rden", rom_rden, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_mode", mode, 0);
        check("rst_freq", freq_sel, 0);
        check("rst_amp", amp_sel, 0);

        // Release with two mode pulses so the first tick samples sawtooth
        rst_n = 1'b1;
        mode_step = 1'b1;
        @(negedge clk);
        check("rden_after_edge", rom_rden, 1);
        @(negedge clk);
        mode_step = 1'b0;
        wait_valid(d);
        check("saw_first", d, 1);
        wait_valid(d);
        check("saw_second", d, 2);
        wait_valid(d);
        check("saw_third", d, 3);

        prev = d;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            wait_valid(d);
            if (prev == 8'd255) begin
                check("saw_wrap", d, 0);
                seen = 1;
                break;
            end
            prev = d;
        end
        check("saw_wrap_seen", seen, 1);

        @(negedge clk);
        pulse_freq();
        skip_valid(1);
        wait_valid(d1);
        wait_valid(d);
        check("freq1_step", 8'(d - d1), 2);
        pulse_freq(); pulse_freq(); pulse_freq();
        skip_valid(1);
        wait_valid(d1);
        wait_valid(d);
        check("freq_wrap_step", 8'(d - d1), 1);

        // Square at amp shift 2 over one full period
        pulse_mode(); pulse_mode(); pulse_mode();
        pulse_amp(); pulse_amp();
        skip_valid(3);
        c_hi = 0; c_lo = 0;
        for (int i = 0; i < 256; i++) begin
            wait_valid(d);
            if (d == 8'd63) c_hi++;
            if (d == 8'd0)  c_lo++;
        end
        check("sq_hi_count", c_hi, 128);
        check("sq_lo_count", c_lo, 128);

        // Triangle, full amplitude, clear aligned with a tick
        pulse_mode(); pulse_mode();
        pulse_amp(); pulse_amp();
        skip_valid(3);
        guard = 0;
        while (m_cnt != DIV - 1 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        check("tick_align", m_cnt, DIV - 1);
        phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        wait_valid(d);
        check("tri_after_clr", d, 0);
        wait_valid(d);
        check("tri_second", d, 2);
        skip_valid(260);

        // Sine from the ROM model
        pulse_mode();
        skip_valid(40);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dout", dout, 0);
        check("midrst_valid", dout_valid, 0);
        check("midrst_rden", rom_rden, 0);
        check("midrst_mode", mode, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_valid(d);
        check("post_rst_sine", d, rom[1]);
        skip_valid(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
